// File: rtl/frame_composer.sv
// Double-buffered 16x16 frame renderer: draws ball and paddles into the back buffer, then swaps
// buffers only on a scanner frame boundary. Define PONG_BALL_TRAIL_EN to also draw the previous ball.
module frame_composer (
  input  logic        clk,
  input  logic        reset,
  input  logic        update,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [15:0] lpaddle,
  input  logic [15:0] rpaddle,
  input  logic        frame_done,
  input  logic [3:0]  row_addr,
  output logic [15:0] row_data,
  output logic        busy,
  output logic        frame_ready,
  output logic        swap,
  output logic        overrun
);

  typedef enum logic [1:0] {StIdle, StRender, StPending} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_cnt_q, row_cnt_d;
  logic [3:0]  x_q, y_q;
  logic [15:0] lpad_q, rpad_q;
  logic        front_sel_q;
  logic        swap_q;
  logic        overrun_q;
  logic [15:0] row_data_q;
  logic [15:0] buf0_q [16];
  logic [15:0] buf1_q [16];

  logic        capture;
  logic        row_we;
  logic        toggle;
  logic        drop;
  logic [15:0] row_pix;

`ifdef PONG_BALL_TRAIL_EN
  logic [3:0] x_prev_q, y_prev_q;
  logic       prev_valid_q, snap_valid_q;

  // The previous position only counts once a real snapshot has been taken, so the
  // all-zero reset snapshot never shows up as a phantom trail pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev_q     <= '0;
      y_prev_q     <= '0;
      prev_valid_q <= 1'b0;
      snap_valid_q <= 1'b0;
    end else if (capture) begin
      x_prev_q     <= x_q;
      y_prev_q     <= y_q;
      prev_valid_q <= snap_valid_q;
      snap_valid_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    row_pix     = '0;
    row_pix[0]  = lpad_q[row_cnt_q];
    row_pix[15] = rpad_q[row_cnt_q];
    if (row_cnt_q == y_q) row_pix[x_q] = 1'b1;
`ifdef PONG_BALL_TRAIL_EN
    if (prev_valid_q && (row_cnt_q == y_prev_q)) row_pix[x_prev_q] = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    capture   = 1'b0;
    row_we    = 1'b0;
    toggle    = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (update) begin
          capture   = 1'b1;
          row_cnt_d = '0;
          state_d   = StRender;
        end
      end
      StRender: begin
        row_we = 1'b1;
        drop   = update;
        if (row_cnt_q == 4'd15) begin
          state_d = StPending;
        end else begin
          row_cnt_d = row_cnt_q + 4'd1;
        end
      end
      StPending: begin
        if (frame_done) begin
          toggle  = 1'b1;
          state_d = StIdle;
        end
        // A fresh update replaces the unshown back buffer; with a same-cycle swap it
        // renders into the buffer that has just become the back.
        if (update) begin
          capture   = 1'b1;
          row_cnt_d = '0;
          state_d   = StRender;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      row_cnt_q   <= '0;
      front_sel_q <= 1'b0;
      swap_q      <= 1'b0;
      overrun_q   <= 1'b0;
      row_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      front_sel_q <= front_sel_q ^ toggle;
      swap_q      <= toggle;
      overrun_q   <= overrun_q | drop;
      row_data_q  <= front_sel_q ? buf1_q[row_addr] : buf0_q[row_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      lpad_q <= '0;
      rpad_q <= '0;
    end else if (capture) begin
      x_q    <= x;
      y_q    <= y;
      lpad_q <= lpaddle;
      rpad_q <= rpaddle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
    end else if (row_we) begin
      if (front_sel_q) buf0_q[row_cnt_q] <= row_pix;
      else             buf1_q[row_cnt_q] <= row_pix;
    end
  end

  assign row_data    = row_data_q;
  assign busy        = (state_q != StIdle);
  assign frame_ready = (state_q == StPending);
  assign swap        = swap_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_composer.sv
// Directed bench for frame_composer; expected rows come from a bench-side frame model and are
// queued when a read is issued, then popped when row_data returns.
module tb_frame_composer;

  logic        clk = 1'b0;
  logic        reset;
  logic        update;
  logic [3:0]  x, y, row_addr;
  logic [15:0] lpaddle, rpaddle;
  logic        frame_done;
  logic [15:0] row_data;
  logic        busy, frame_ready, swap, overrun;

  always #5 clk = ~clk;

  frame_composer dut (
    .clk        (clk),
    .reset      (reset),
    .update     (update),
    .x          (x),
    .y          (y),
    .lpaddle    (lpaddle),
    .rpaddle    (rpaddle),
    .frame_done (frame_done),
    .row_addr   (row_addr),
    .row_data   (row_data),
    .busy       (busy),
    .frame_ready(frame_ready),
    .swap       (swap),
    .overrun    (overrun)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [15:0] front_m [16];
  logic [15:0] pend_m [16];
  logic [3:0]  sx_m, sy_m, px_m, py_m;
  logic        sv_m, pv_m;
  logic [15:0] trail_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      front_m[r] = '0;
      pend_m[r]  = '0;
    end
    sx_m = '0; sy_m = '0; px_m = '0; py_m = '0;
    sv_m = 1'b0; pv_m = 1'b0;
  endtask

  task automatic model_accept(input logic [3:0] xi, input logic [3:0] yi,
                              input logic [15:0] lp, input logic [15:0] rp);
    logic [15:0] row;
    pv_m = sv_m; px_m = sx_m; py_m = sy_m;
    sx_m = xi; sy_m = yi; sv_m = 1'b1;
    for (int r = 0; r < 16; r++) begin
      row     = '0;
      row[0]  = lp[r];
      row[15] = rp[r];
      if (4'(r) == yi) row[xi] = 1'b1;
`ifdef PONG_BALL_TRAIL_EN
      if (pv_m && (4'(r) == py_m)) row[px_m] = 1'b1;
`endif
      pend_m[r] = row;
    end
  endtask

  task automatic model_swap();
    for (int r = 0; r < 16; r++) front_m[r] = pend_m[r];
  endtask

  task automatic send(input logic [3:0] xi, input logic [3:0] yi,
                      input logic [15:0] lp, input logic [15:0] rp, input logic fd);
    x = xi; y = yi; lpaddle = lp; rpaddle = rp;
    update = 1'b1; frame_done = fd;
    tick();
    update = 1'b0; frame_done = 1'b0;
  endtask

  task automatic read_frame(input string tag);
    for (int r = 0; r < 16; r++) begin
      row_addr = 4'(r);
      exp_q.push_back(front_m[r]);
      tick();
      check(tag, row_data, exp_q.pop_front());
    end
  endtask

  task automatic wait_ready(input int exp_n);
    int n = 0;
    while (frame_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ready_latency", 16'(n), 16'(exp_n));
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    model_swap();
    check("swap_pulse", 16'(swap), 16'h1);
    check("ready_cleared", 16'(frame_ready), 16'h0);
  endtask

  initial begin
    reset = 1'b1; update = 1'b0; frame_done = 1'b0;
    x = '0; y = '0; lpaddle = '0; rpaddle = '0; row_addr = '0;
    model_reset();
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("reset_busy", 16'(busy), 16'h0);
    check("reset_overrun", 16'(overrun), 16'h0);
    check("reset_ready", 16'(frame_ready), 16'h0);
    check("reset_swap", 16'(swap), 16'h0);
    read_frame("reset_row");

    // Basic render, swap and first post-swap read
    send(4'd5, 4'd3, 16'h0070, 16'h0E00, 1'b0);
    model_accept(4'd5, 4'd3, 16'h0070, 16'h0E00);
    check("busy_after_update", 16'(busy), 16'h1);
    wait_ready(16);
    check("busy_pending", 16'(busy), 16'h1);
    pulse_done();
    check("busy_after_swap", 16'(busy), 16'h0);
    row_addr = 4'd3;
    tick();
    check("first_read_new_front", row_data, front_m[3]);
    check("swap_single", 16'(swap), 16'h0);
    read_frame("frame1");

    // frame_done during render is ignored
    send(4'd10, 4'd12, 16'h8001, 16'h00FF, 1'b0);
    model_accept(4'd10, 4'd12, 16'h8001, 16'h00FF);
    tick(); tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("no_swap_in_render", 16'(swap), 16'h0);
    check("busy_in_render", 16'(busy), 16'h1);
    wait_ready(13);
    read_frame("held_front");
    pulse_done();
    read_frame("frame2");

    // Dropped update sets sticky overrun; frame keeps first snapshot
    send(4'd7, 4'd8, 16'h0F00, 16'h000F, 1'b0);
    model_accept(4'd7, 4'd8, 16'h0F00, 16'h000F);
    tick(); tick(); tick(); tick();
    send(4'd1, 4'd1, 16'hFFFF, 16'hFFFF, 1'b0);
    check("overrun_set", 16'(overrun), 16'h1);
    wait_ready(11);
    pulse_done();
    read_frame("overrun_frame");
    check("overrun_sticky", 16'(overrun), 16'h1);

    // Reset mid-render clears everything, including both buffers
    send(4'd9, 4'd9, 16'h1234, 16'h5678, 1'b0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("overrun_cleared", 16'(overrun), 16'h0);
    check("busy_cleared", 16'(busy), 16'h0);
    check("ready_after_reset", 16'(frame_ready), 16'h0);
    read_frame("post_reset");
    pulse_done_skip: begin
      check("idle_stays_idle", 16'(busy), 16'h0);
    end

    // Update in PENDING re-renders without overrun
    send(4'd4, 4'd4, 16'h0010, 16'h0000, 1'b0);
    model_accept(4'd4, 4'd4, 16'h0010, 16'h0000);
    wait_ready(16);
    send(4'd12, 4'd6, 16'h0000, 16'h0040, 1'b0);
    model_accept(4'd12, 4'd6, 16'h0000, 16'h0040);
    check("rerender_no_overrun", 16'(overrun), 16'h0);
    check("rerender_busy", 16'(busy), 16'h1);
    check("rerender_not_ready", 16'(frame_ready), 16'h0);
    wait_ready(16);

    // Same-cycle frame_done and update: swap plus immediate new render
    send(4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1);
    model_swap();
    model_accept(4'd0, 4'd0, 16'h0000, 16'h0000);
    check("combo_swap", 16'(swap), 16'h1);
    check("combo_busy", 16'(busy), 16'h1);
    check("combo_not_ready", 16'(frame_ready), 16'h0);
    read_frame("combo_front");
    wait_ready(0);
    pulse_done();
    read_frame("corner_frame");

    // Ball trail sequence
    send(4'd2, 4'd2, 16'h0000, 16'h0000, 1'b0);
    model_accept(4'd2, 4'd2, 16'h0000, 16'h0000);
    wait_ready(16);
    pulse_done();
    send(4'd3, 4'd2, 16'h0000, 16'h0000, 1'b0);
    model_accept(4'd3, 4'd2, 16'h0000, 16'h0000);
    wait_ready(16);
    pulse_done();
`ifdef PONG_BALL_TRAIL_EN
    trail_exp = 16'h000C;
`else
    trail_exp = 16'h0008;
`endif
    row_addr = 4'd2;
    tick();
    check("trail_row2", row_data, trail_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
